// File: rtl/tx_generator.sv
// tx_generator: LFSR-driven transaction stimulus generator with result accounting
module tx_generator #(
  parameter int USER_WIDTH    = 10,
  parameter int BALANCE_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic                     cfg_stop,
  input  logic [31:0]              cfg_count,
  input  logic [7:0]               cfg_gap,
  input  logic [31:0]              cfg_seed,
  input  logic [BALANCE_WIDTH-1:0] cfg_amt_mask,
  output logic                     m_valid,
  output logic                     m_opcode,
  output logic [USER_WIDTH-1:0]    m_user_a,
  output logic [USER_WIDTH-1:0]    m_user_b,
  output logic [BALANCE_WIDTH-1:0] m_amount_0,
  output logic [BALANCE_WIDTH-1:0] m_amount_1,
  input  logic                     r_valid,
  input  logic                     r_success,
  output logic                     busy,
  output logic                     done,
  output logic                     err_timeout,
  output logic [31:0]              sent_cnt,
  output logic [31:0]              ok_cnt,
  output logic [31:0]              fail_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_t;
  state_t state, state_nxt;
  logic [31:0] lfsr;
  logic [7:0]  gap_cnt;
  logic [3:0]  drain_cnt;
  logic        start_go, issue, balanced, drain_exit;
  logic [31:0] sent_next, lfsr_step, swapped;
  assign start_go   = (state == IDLE) && cfg_start;
  assign issue      = (state == ISSUE) && !cfg_stop;
  assign sent_next  = sent_cnt + 32'd1;
  assign balanced   = sent_cnt == ok_cnt + fail_cnt;
  assign drain_exit = (state == DRAIN) && (balanced || drain_cnt == 4'd15);
  assign lfsr_step  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  assign swapped    = {lfsr[15:0], lfsr[31:16]};
  assign busy       = state != IDLE;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next-state: stop beats count-reached, count-reached beats gap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = cfg_start ? ISSUE : IDLE;
      ISSUE: state_nxt = cfg_stop ? DRAIN :
                         (cfg_count != 32'd0 && sent_next == cfg_count) ? DRAIN :
                         (cfg_gap != 8'd0) ? GAP : ISSUE;
      GAP:   state_nxt = cfg_stop ? DRAIN : (gap_cnt == 8'd0) ? ISSUE : GAP;
      DRAIN: state_nxt = drain_exit ? IDLE : DRAIN;
    endcase
  end
  // LFSR and registered beat fields, taken from the pre-step LFSR value
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lfsr       <= 32'd1;
      m_valid    <= 1'b0;
      m_opcode   <= 1'b0;
      m_user_a   <= '0;
      m_user_b   <= '0;
      m_amount_0 <= '0;
      m_amount_1 <= '0;
    end else begin
      m_valid <= issue;
      if (start_go) lfsr <= (cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
      else if (issue) lfsr <= lfsr_step;
      if (issue) begin
        m_user_a   <= lfsr[USER_WIDTH-1:0];
        m_user_b   <= lfsr[31:32-USER_WIDTH];
        m_opcode   <= lfsr[16];
        m_amount_0 <= BALANCE_WIDTH'(lfsr) & cfg_amt_mask;
        m_amount_1 <= BALANCE_WIDTH'(swapped) & cfg_amt_mask;
      end
    end
  // run statistics; results are counted in every state, start clears them
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sent_cnt <= '0;
      ok_cnt   <= '0;
      fail_cnt <= '0;
    end else begin
      sent_cnt <= start_go ? 32'd0 : issue ? sent_next : sent_cnt;
      ok_cnt   <= start_go ? 32'd0 : ok_cnt + 32'(r_valid & r_success);
      fail_cnt <= start_go ? 32'd0 : fail_cnt + 32'(r_valid & ~r_success);
    end
  // gap countdown loaded on each beat, drain age counted while draining
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gap_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      gap_cnt   <= issue ? cfg_gap - 8'd1 : (state == GAP) ? gap_cnt - 8'd1 : gap_cnt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
    end
  // done pulse on drain exit; sticky timeout flag cleared by a new run
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done        <= drain_exit;
      err_timeout <= start_go ? 1'b0 : (drain_exit && !balanced) ? 1'b1 : err_timeout;
    end
endmodule

// File: tb/tb_tx_generator.sv
// tb_tx_generator: directed scenarios checked against a cycle model and literal expectations
module tb_tx_generator;
  localparam int UW = 10;
  localparam int BW = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_start = 1'b0, cfg_stop = 1'b0;
  logic [31:0] cfg_count = '0;
  logic [7:0] cfg_gap = '0;
  logic [31:0] cfg_seed = '0;
  logic [BW-1:0] cfg_amt_mask = '1;
  logic r_valid = 1'b0, r_success = 1'b0;
  logic m_valid, m_opcode, busy, done, err_timeout;
  logic [UW-1:0] m_user_a, m_user_b;
  logic [BW-1:0] m_amount_0, m_amount_1;
  logic [31:0] sent_cnt, ok_cnt, fail_cnt;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  tx_generator #(.USER_WIDTH(UW), .BALANCE_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_count(cfg_count), .cfg_gap(cfg_gap), .cfg_seed(cfg_seed),
    .cfg_amt_mask(cfg_amt_mask), .m_valid(m_valid), .m_opcode(m_opcode),
    .m_user_a(m_user_a), .m_user_b(m_user_b), .m_amount_0(m_amount_0),
    .m_amount_1(m_amount_1), .r_valid(r_valid), .r_success(r_success),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .sent_cnt(sent_cnt), .ok_cnt(ok_cnt), .fail_cnt(fail_cnt)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction
  // behavioural model: a run is either issuing (with a countdown to the next beat) or draining
  logic e_valid, e_op, e_done, e_err;
  logic [UW-1:0] e_ua, e_ub;
  logic [BW-1:0] e_a0, e_a1;
  logic [31:0] e_sent, e_ok, e_fail, e_l;
  bit e_run, e_drain, e_bal, e_fresh;
  int e_wait, e_age;
  task automatic model_step();
    if (rst) begin
      e_valid = 0; e_op = 0; e_done = 0; e_err = 0; e_ua = '0; e_ub = '0;
      e_a0 = '0; e_a1 = '0; e_sent = 0; e_ok = 0; e_fail = 0; e_l = 1;
      e_run = 0; e_drain = 0; e_wait = 0; e_age = 0;
    end else begin
      e_bal = e_sent == e_ok + e_fail;
      e_fresh = 0;
      e_valid = 0;
      e_done = 0;
      if (!e_run && !e_drain) begin
        if (cfg_start) begin
          e_fresh = 1; e_l = (cfg_seed == 0) ? 32'd1 : cfg_seed;
          e_sent = 0; e_err = 0; e_run = 1; e_wait = 0;
        end
      end else if (e_run) begin
        if (cfg_stop) begin
          e_run = 0; e_drain = 1; e_age = 0;
        end else if (e_wait > 0) e_wait--;
        else begin
          e_valid = 1;
          e_ua = e_l[UW-1:0];
          e_ub = e_l[31:32-UW];
          e_op = e_l[16];
          e_a0 = {32'h0, e_l} & cfg_amt_mask;
          e_a1 = {32'h0, e_l[15:0], e_l[31:16]} & cfg_amt_mask;
          e_sent++;
          e_l = step(e_l);
          if (cfg_count != 0 && e_sent == cfg_count) begin
            e_run = 0; e_drain = 1; e_age = 0;
          end else e_wait = cfg_gap;
        end
      end else begin
        if (e_bal) begin
          e_drain = 0; e_done = 1;
        end else if (e_age == 15) begin
          e_drain = 0; e_done = 1; e_err = 1;
        end else e_age++;
      end
      if (e_fresh) begin
        e_ok = 0; e_fail = 0;
      end else begin
        if (r_valid && r_success) e_ok++;
        if (r_valid && !r_success) e_fail++;
      end
    end
  endtask
  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end
  // compare every output against the model away from the active edge
  initial forever begin
    @(negedge clk);
    check("m_valid", m_valid, e_valid);
    check("m_opcode", m_opcode, e_op);
    check("m_user_a", m_user_a, e_ua);
    check("m_user_b", m_user_b, e_ub);
    check("m_amount_0", m_amount_0, e_a0);
    check("m_amount_1", m_amount_1, e_a1);
    check("busy", busy, e_run || e_drain);
    check("done", done, e_done);
    check("err_timeout", err_timeout, e_err);
    check("sent_cnt", sent_cnt, e_sent);
    check("ok_cnt", ok_cnt, e_ok);
    check("fail_cnt", fail_cnt, e_fail);
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic start_run();
    @(negedge clk) cfg_start = 1;
    @(negedge clk) cfg_start = 0;
  endtask
  task automatic wait_done(input string name, input int lim, output int k);
    k = 0;
    while (!done && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(name, done, 1);
  endtask
  int n, nd, last, k;
  initial begin
    repeat (3) @(negedge clk);
    check("rst m_valid", m_valid, 0);
    check("rst busy", busy, 0);
    check("rst sent", sent_cnt, 0);
    check("rst amount_1", m_amount_1, 0);
    #2 rst = 0;
    // single beat from seed 0
    cfg_seed = 0; cfg_count = 1; cfg_gap = 0; cfg_amt_mask = '1;
    start_run();
    @(negedge clk);
    check("s1 valid", m_valid, 1);
    check("s1 user_a", m_user_a, 1);
    check("s1 user_b", m_user_b, 0);
    check("s1 opcode", m_opcode, 0);
    check("s1 amount_0", m_amount_0, 1);
    check("s1 amount_1", m_amount_1, 64'h10000);
    @(negedge clk);
    r_valid = 1; r_success = 1;
    @(negedge clk) r_valid = 0;
    wait_done("s1 done", 10, k);
    check("s1 ok", ok_cnt, 1);
    check("s1 busy", busy, 0);
    // four beats, period 3
    cfg_count = 4; cfg_gap = 2; cfg_seed = 32'h1234_5678; cfg_amt_mask = 64'hFFFF_FFFF_0000_FFFF;
    start_run();
    n = 0; nd = 0; last = -1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      r_valid = m_valid; r_success = 1;
      if (m_valid) begin
        if (n > 0) check("s2 spacing", 64'(i - last), 3);
        last = i;
        n++;
      end
      if (done) nd++;
    end
    r_valid = 0;
    check("s2 beats", n, 4);
    check("s2 done pulses", nd, 1);
    check("s2 sent", sent_cnt, 4);
    // unlimited run stopped after ten beats, all failing
    cfg_count = 0; cfg_gap = 0; cfg_seed = 32'h0000_ACE1; cfg_amt_mask = '1;
    start_run();
    n = 0;
    for (int i = 0; i < 40 && n < 10; i++) begin
      @(negedge clk);
      r_valid = m_valid; r_success = 0;
      if (m_valid) n++;
    end
    cfg_stop = 1;
    @(negedge clk);
    cfg_stop = 0; r_valid = 0;
    check("s3 no beat on stop", m_valid, 0);
    check("s3 sent", sent_cnt, 10);
    wait_done("s3 done", 10, k);
    check("s3 fail", fail_cnt, 10);
    // results never returned -> drain timeout
    cfg_count = 2; cfg_seed = 32'h0BAD_F00D;
    start_run();
    @(negedge clk);
    @(negedge clk);
    check("s4 second beat", m_valid, 1);
    wait_done("s4 done", 40, k);
    check("s4 timeout latency", k, 16);
    check("s4 err", err_timeout, 1);
    // start during a run is ignored
    cfg_count = 6; cfg_gap = 1; cfg_seed = 32'hDEAD_BEEF;
    start_run();
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cfg_start = (i == 4);
      r_valid = m_valid; r_success = 1;
      if (done) nd++;
    end
    r_valid = 0;
    check("s5 sent", sent_cnt, 6);
    check("s5 ok", ok_cnt, 6);
    check("s5 done pulses", nd, 1);
    check("s5 err cleared", err_timeout, 0);
    // start and stop together in IDLE start a run
    cfg_count = 1; cfg_gap = 0;
    @(negedge clk) begin cfg_start = 1; cfg_stop = 1; end
    @(negedge clk) begin cfg_start = 0; cfg_stop = 0; end
    check("s6 busy", busy, 1);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r_valid = m_valid; r_success = 1;
      if (done) nd++;
    end
    r_valid = 0;
    check("s6 sent", sent_cnt, 1);
    check("s6 done pulses", nd, 1);
    // reset mid-run
    cfg_count = 8; cfg_seed = 7;
    start_run();
    repeat (3) @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
    check("s7 valid", m_valid, 0);
    check("s7 busy", busy, 0);
    check("s7 sent", sent_cnt, 0);
    check("s7 user_a", m_user_a, 0);
    check("s7 done", done, 0);
    #2 rst = 0;
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("s7 no done", nd, 0);
    cfg_count = 1; cfg_seed = 32'h0000_0155;
    start_run();
    @(negedge clk);
    check("s7 fresh user_a", m_user_a, 10'h155);
    check("s7 fresh amount_0", m_amount_0, 64'h155);
    check("s7 fresh sent", sent_cnt, 1);
    r_valid = 1; r_success = 1;
    @(negedge clk) r_valid = 0;
    wait_done("s7 done", 10, k);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_generator.md
TX_GENERATOR -- requirements
Module: tx_generator

Interface
REQ-001 SHALL have parameter USER_WIDTH, default 10, user index width (legal 1..16).
REQ-002 SHALL have parameter BALANCE_WIDTH, default 64, amount width (legal >= 32).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  async active-high reset.
- cfg_start  in  1  pulse; begin a run.
- cfg_stop  in  1  pulse; abort issuing, then drain.
- cfg_count  in  32  transactions per run; 0 = unlimited.
- cfg_gap  in  8  idle cycles between transactions.
- cfg_seed  in  32  LFSR seed.
- cfg_amt_mask  in  BALANCE_WIDTH  AND-mask applied to amounts.
- m_valid  out  1  transaction beat to the ledger input.
- m_opcode  out  1  0 = USDC transfer, 1 = swap.
- m_user_a, m_user_b  out  USER_WIDTH each  user indices.
- m_amount_0, m_amount_1  out  BALANCE_WIDTH each  amounts.
- r_valid  in  1  ledger result valid.
- r_success  in  1  ledger result success.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- err_timeout  out  1  sticky drain-timeout flag.
- sent_cnt, ok_cnt, fail_cnt  out  32 each  run statistics.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, GAP, DRAIN; busy = (state != IDLE).
REQ-006 When cfg_start is sampled in IDLE, the block SHALL load the LFSR with cfg_seed (0 replaced by 1), clear sent_cnt/ok_cnt/fail_cnt/err_timeout, and go to ISSUE.
REQ-007 cfg_start outside IDLE SHALL be ignored; cfg_stop in IDLE SHALL be ignored; start and stop in the same IDLE cycle SHALL be treated as start only.
REQ-008 The LFSR SHALL be 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 0x80200003), and SHALL step once per issued beat.
REQ-009 Each clock edge in ISSUE SHALL register exactly one beat: m_valid=1, sent_cnt+1, with fields taken from the pre-step LFSR value L.
REQ-010 Field derivation SHALL be:
- m_user_a = L[USER_WIDTH-1:0].
- m_user_b = L[31:32-USER_WIDTH].
- m_opcode = L[16].
- m_amount_0 = zero-extended L AND cfg_amt_mask.
- m_amount_1 = zero-extended {L[15:0],L[31:16]} AND cfg_amt_mask.
REQ-011 All beat outputs SHALL be registered; m_valid SHALL be 0 on every edge not issuing; fields SHALL hold their last value when m_valid=0.
REQ-012 After an issue edge:
- next state = DRAIN if cfg_count != 0 and the new sent_cnt == cfg_count;
- else ISSUE if cfg_gap == 0;
- else GAP for exactly cfg_gap cycles, then ISSUE.
- Beat period is therefore cfg_gap+1 cycles.
REQ-013 cfg_stop sampled in ISSUE or GAP SHALL move to DRAIN with no beat issued on that edge; stop and count-reached together SHALL also go to DRAIN.
REQ-014 r_valid&r_success SHALL increment ok_cnt, and r_valid&!r_success SHALL increment fail_cnt, in every state including IDLE.
REQ-015 DRAIN SHALL exit to IDLE when sent_cnt == ok_cnt+fail_cnt, pulsing done for one cycle.
REQ-016 If DRAIN lasts 16 cycles without balance, the block SHALL set err_timeout, exit to IDLE and pulse done.
REQ-017 All 32-bit counters SHALL wrap modulo 2^32.
REQ-018 cfg_* inputs SHALL be sampled live each cycle (no shadow copy) except cfg_seed, which is used only at start.

Reset
REQ-019 While rst=1, the block SHALL be in state IDLE and hold:
- LFSR = 1.
- Outputs m_valid, busy, done, err_timeout, all counters and all beat fields = 0.
REQ-020 Reset asserted mid-run SHALL abandon the run immediately and issue no done pulse.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- seed=0, count=1, gap=0, mask=all-ones, start -> one beat with user_a=1, user_b=0, opcode=0, amount_0=1, amount_1=0x10000; r_valid&r_success 2 cycles later -> ok_cnt=1, done pulse, busy=0.
- count=4, gap=2 -> exactly 4 beats spaced 3 cycles apart, sent_cnt=4.
- count=0, gap=0; stop after 10 beats; all results returned with r_success=0 -> fail_cnt=10, done pulse, no beat on the stop edge.
- count=2; results never returned -> err_timeout=1 and done 16 cycles after DRAIN entry.
- start during a run -> ignored, counters continue; start+stop together in IDLE -> run starts.
- rst mid-run with count=8 -> all outputs 0 next cycle, no done pulse, next start behaves as fresh.
